// File: rtl/true_dual_port_ram.sv
// True dual-port byte-writable RAM with power-on clear sequencer,
// configurable read latency (1 or 2) and same-port read-during-write mode.
module true_dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic [NB-1:0]         we_a,
  input  logic [AW-1:0]         addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic [NB-1:0]         we_b,
  input  logic [AW-1:0]         addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_b,
  output logic                  init_done,
  output logic                  collision
);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("true_dual_port_ram: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("true_dual_port_ram: RD_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("true_dual_port_ram: DEPTH must be at least 2");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_next;
  logic [AW-1:0]         clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_a, acc_b, same_addr;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;

  // Lane-wise result of a write cycle; port A owns any lane both ports write.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] data_a,
    input logic [NB-1:0]         lanes_a,
    input logic [DATA_WIDTH-1:0] data_b,
    input logic [NB-1:0]         lanes_b
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes_a[i])      w[i*8 +: 8] = data_a[i*8 +: 8];
      else if (lanes_b[i]) w[i*8 +: 8] = data_b[i*8 +: 8];
    end
    return w;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == AW'(DEPTH - 1)) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  assign init_done = (state == READY);
  assign acc_a     = en_a && init_done;
  assign acc_b     = en_b && init_done;
  assign same_addr = (addr_a == addr_b);

  // Write-first only applies to a port's own write; a read always sees the old word.
  always_comb begin
    rd_word_a = mem[addr_a];
    rd_word_b = mem[addr_b];
    if (RDW_MODE == 1 && |we_a)
      rd_word_a = merge(mem[addr_a], din_a, we_a, din_b,
                        (acc_b && same_addr) ? we_b : '0);
    if (RDW_MODE == 1 && |we_b)
      rd_word_b = merge(mem[addr_b], din_a, (acc_a && same_addr) ? we_a : '0,
                        din_b, we_b);
  end

  // NOTE: the array has no reset (it maps onto RAM macros); the CLEAR sweep
  // zeroes it instead. Port A lanes are assigned last so they win on overlap.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (acc_b && we_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
      for (int i = 0; i < NB; i++)
        if (acc_a && we_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= acc_a && acc_b && same_addr && (|we_a || |we_b);
  end

  if (RD_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_a <= 1'b0;
        valid_b <= 1'b0;
        dout_a  <= '0;
        dout_b  <= '0;
      end else begin
        valid_a <= acc_a;
        valid_b <= acc_b;
        if (acc_a) dout_a <= rd_word_a;
        if (acc_b) dout_b <= rd_word_b;
      end
    end
  end else begin : g_lat2
    logic                  s1_valid_a, s1_valid_b;
    logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;

    // The intermediate stage is reset too, so in-flight reads die with rst.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_a <= 1'b0;
        s1_valid_b <= 1'b0;
        s1_data_a  <= '0;
        s1_data_b  <= '0;
        valid_a    <= 1'b0;
        valid_b    <= 1'b0;
        dout_a     <= '0;
        dout_b     <= '0;
      end else begin
        s1_valid_a <= acc_a;
        s1_valid_b <= acc_b;
        if (acc_a) s1_data_a <= rd_word_a;
        if (acc_b) s1_data_b <= rd_word_b;
        valid_a <= s1_valid_a;
        valid_b <= s1_valid_b;
        if (s1_valid_a) dout_a <= s1_data_a;
        if (s1_valid_b) dout_b <= s1_data_b;
      end
    end
  end

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Directed bench for true_dual_port_ram: three instances (read-first/L1,
// write-first/L1, read-first/L2), all with DEPTH=16, sharing clk and rst.
module tb_true_dual_port_ram;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en_a   [3];
  logic [NB-1:0] we_a   [3];
  logic [AW-1:0] addr_a [3];
  logic [DW-1:0] din_a  [3];
  logic [DW-1:0] dout_a [3];
  logic          valid_a[3];
  logic          en_b   [3];
  logic [NB-1:0] we_b   [3];
  logic [AW-1:0] addr_b [3];
  logic [DW-1:0] din_b  [3];
  logic [DW-1:0] dout_b [3];
  logic          valid_b[3];
  logic          init_done[3];
  logic          collision[3];

  true_dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]), .din_a(din_a[0]),
    .dout_a(dout_a[0]), .valid_a(valid_a[0]),
    .en_b(en_b[0]), .we_b(we_b[0]), .addr_b(addr_b[0]), .din_b(din_b[0]),
    .dout_b(dout_b[0]), .valid_b(valid_b[0]),
    .init_done(init_done[0]), .collision(collision[0]));

  true_dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(1), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]), .din_a(din_a[1]),
    .dout_a(dout_a[1]), .valid_a(valid_a[1]),
    .en_b(en_b[1]), .we_b(we_b[1]), .addr_b(addr_b[1]), .din_b(din_b[1]),
    .dout_b(dout_b[1]), .valid_b(valid_b[1]),
    .init_done(init_done[1]), .collision(collision[1]));

  true_dual_port_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(2), .RDW_MODE(0)) dut2 (
    .clk(clk), .rst(rst),
    .en_a(en_a[2]), .we_a(we_a[2]), .addr_a(addr_a[2]), .din_a(din_a[2]),
    .dout_a(dout_a[2]), .valid_a(valid_a[2]),
    .en_b(en_b[2]), .we_b(we_b[2]), .addr_b(addr_b[2]), .din_b(din_b[2]),
    .dout_b(dout_b[2]), .valid_b(valid_b[2]),
    .init_done(init_done[2]), .collision(collision[2]));

  typedef struct {
    logic          en_a;
    logic [NB-1:0] we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          en_b;
    logic [NB-1:0] we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic          xv_a;
    logic [DW-1:0] xd_a;
    logic          xv_b;
    logic [DW-1:0] xd_b;
    logic          xcol;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
    input logic eb, input logic [NB-1:0] wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
    input logic xva, input logic [DW-1:0] xda, input logic xvb, input logic [DW-1:0] xdb,
    input logic xc);
    vec_t v;
    v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.din_a = da;
    v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.din_b = db;
    v.xv_a = xva; v.xd_a = xda; v.xv_b = xvb; v.xd_b = xdb; v.xcol = xc;
    return v;
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      en_a[d] = 1'b0; we_a[d] = '0; addr_a[d] = '0; din_a[d] = '0;
      en_b[d] = 1'b0; we_b[d] = '0; addr_b[d] = '0; din_b[d] = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_pulse();
    logic p;
    p = 1'b0;
    for (int d = 0; d < 3; d++) p = p | valid_a[d] | valid_b[d] | collision[d];
    return p;
  endfunction

  // Counts edges from reset release until init_done; flags any pulse seen meanwhile.
  task automatic wait_init(input string tag);
    int  cycles;
    logic stray;
    cycles = 0;
    stray  = 1'b0;
    while (cycles < 40) begin
      cyc();
      cycles++;
      if (init_done[0]) break;
      stray = stray | any_pulse();
    end
    check({tag, " clear cycles"}, cycles, DEPTH);
    check({tag, " init_done all"}, {init_done[0], init_done[1], init_done[2]}, 3'b111);
    check({tag, " no pulses in CLEAR"}, stray, 1'b0);
  endtask

  vec_t tbl[12];

  initial begin
    logic stray;

    tbl[0]  = mk(1, 4'h0, 4'd2,  32'h0,        1, 4'h0, 4'd15, 32'h0,        1, 32'h00000000, 1, 32'h00000000, 0);
    tbl[1]  = mk(1, 4'hF, 4'd5,  32'hDEADBEEF, 0, 4'h0, 4'd0,  32'h0,        1, 32'h00000000, 0, 32'h00000000, 0);
    tbl[2]  = mk(1, 4'h3, 4'd5,  32'h11223344, 0, 4'h0, 4'd0,  32'h0,        1, 32'hDEADBEEF, 0, 32'h00000000, 0);
    tbl[3]  = mk(0, 4'h0, 4'd0,  32'h0,        1, 4'h0, 4'd5,  32'h0,        0, 32'hDEADBEEF, 1, 32'hDEAD3344, 0);
    tbl[4]  = mk(1, 4'hC, 4'd3,  32'hAAAAAAAA, 1, 4'h6, 4'd3,  32'hBBBBBBBB, 1, 32'h00000000, 1, 32'h00000000, 1);
    tbl[5]  = mk(1, 4'h0, 4'd3,  32'h0,        1, 4'h0, 4'd3,  32'h0,        1, 32'hAAAABB00, 1, 32'hAAAABB00, 0);
    tbl[6]  = mk(1, 4'hF, 4'd7,  32'h12345678, 1, 4'h0, 4'd7,  32'h0,        1, 32'h00000000, 1, 32'h00000000, 1);
    tbl[7]  = mk(1, 4'h0, 4'd7,  32'h0,        1, 4'h1, 4'd7,  32'h000000FF, 1, 32'h12345678, 1, 32'h12345678, 1);
    tbl[8]  = mk(1, 4'h0, 4'd7,  32'h0,        0, 4'h0, 4'd0,  32'h0,        1, 32'h123456FF, 0, 32'h12345678, 0);
    tbl[9]  = mk(0, 4'h0, 4'd0,  32'h0,        0, 4'h0, 4'd0,  32'h0,        0, 32'h123456FF, 0, 32'h12345678, 0);
    tbl[10] = mk(1, 4'h8, 4'd15, 32'h55667788, 1, 4'hF, 4'd14, 32'h99AABBCC, 1, 32'h00000000, 1, 32'h00000000, 0);
    tbl[11] = mk(1, 4'h0, 4'd14, 32'h0,        1, 4'h0, 4'd15, 32'h0,        1, 32'h99AABBCC, 1, 32'h55000000, 0);

    idle_all();
    #3;
    check("reset dout_a", dout_a[0], 32'h0);
    check("reset valid_a", valid_a[0], 1'b0);
    check("reset init_done", init_done[0], 1'b0);
    check("reset collision", collision[0], 1'b0);

    // Requests during CLEAR must be ignored: colliding writes to addr 2.
    @(negedge clk);
    rst = 1'b0;
    en_a[0] = 1'b1; we_a[0] = 4'hF; addr_a[0] = 4'd2; din_a[0] = 32'hFFFFFFFF;
    en_b[0] = 1'b1; we_b[0] = 4'hF; addr_b[0] = 4'd2; din_b[0] = 32'hEEEEEEEE;
    wait_init("init1");
    idle_all();

    for (int i = 0; i < 12; i++) begin
      en_a[0] = tbl[i].en_a; we_a[0] = tbl[i].we_a; addr_a[0] = tbl[i].addr_a; din_a[0] = tbl[i].din_a;
      en_b[0] = tbl[i].en_b; we_b[0] = tbl[i].we_b; addr_b[0] = tbl[i].addr_b; din_b[0] = tbl[i].din_b;
      cyc();
      check($sformatf("v%0d valid_a", i), valid_a[0], tbl[i].xv_a);
      check($sformatf("v%0d dout_a", i), dout_a[0], tbl[i].xd_a);
      check($sformatf("v%0d valid_b", i), valid_b[0], tbl[i].xv_b);
      check($sformatf("v%0d dout_b", i), dout_b[0], tbl[i].xd_b);
      check($sformatf("v%0d collision", i), collision[0], tbl[i].xcol);
    end
    idle_all();

    // Write-first instance: same-port writes return the merged word.
    en_a[1] = 1'b1; we_a[1] = 4'hF; addr_a[1] = 4'd5; din_a[1] = 32'hDEADBEEF;
    cyc();
    check("wf first write dout_a", dout_a[1], 32'hDEADBEEF);
    we_a[1] = 4'h3; din_a[1] = 32'h11223344;
    cyc();
    check("wf second write valid_a", valid_a[1], 1'b1);
    check("wf second write dout_a", dout_a[1], 32'hDEAD3344);
    we_a[1] = 4'h0;
    cyc();
    check("wf readback dout_a", dout_a[1], 32'hDEAD3344);
    idle_all();

    // Latency-2 instance: preload 1..4, then four back-to-back reads on B.
    for (int k = 0; k < 4; k++) begin
      en_a[2] = 1'b1; we_a[2] = 4'hF; addr_a[2] = AW'(k); din_a[2] = DW'(k + 1);
      cyc();
    end
    idle_all();
    cyc();
    cyc();
    for (int c = 0; c < 7; c++) begin
      en_b[2] = (c < 4); addr_b[2] = AW'(c);
      cyc();
      check($sformatf("L2 c%0d valid_b", c), valid_b[2], (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) check($sformatf("L2 c%0d dout_b", c), dout_b[2], DW'(c));
    end
    check("L2 dout_b holds", dout_b[2], 32'd4);

    // Reset with a latency-2 read in flight.
    en_b[2] = 1'b1; addr_b[2] = 4'd2;
    cyc();
    idle_all();
    #2;
    rst = 1'b1;
    #1;
    check("async rst dout_b L2", dout_b[2], 32'h0);
    check("async rst valid_b L2", valid_b[2], 1'b0);
    check("async rst dout_a", dout_a[0], 32'h0);
    check("async rst init_done", init_done[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      stray = stray | any_pulse();
    end
    check("no stray valid after rst", stray, 1'b0);

    // Second reset mid-CLEAR with the counter at 7.
    #2;
    rst = 1'b1;
    #1;
    check("midclear rst init_done", init_done[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("init2");

    en_a[0] = 1'b1; addr_a[0] = 4'd5;
    en_b[0] = 1'b1; addr_b[0] = 4'd3;
    cyc();
    check("post-clear addr5", dout_a[0], 32'h0);
    check("post-clear addr3", dout_b[0], 32'h0);
    check("post-clear valid_a", valid_a[0], 1'b1);
    idle_all();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
